uart_word_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_byte.sv | 124 ++++++++++++
 rtl/uart_word_rx.sv | 98 +++++++++
 tb/tb_uart_word_rx.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the serial word receiver.
//   rx_state_t : byte-receiver FSM states
//   byte_t     : one received data byte
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchronizer, byte FSM, bit/cycle counters.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_rx           : asynchronous serial input, idles high
//   o_byte         : assembled byte, valid while o_byte_ok is high
//   o_byte_ok      : combinational pulse in the cycle the good stop bit is sampled
//   o_frame_err    : combinational pulse in the cycle a bad stop bit is sampled
//   o_idle         : FSM is in IDLE
//   o_start        : FSM is in IDLE and sees a start edge this cycle
//
// state     | meaning
// ----------+---------------------------------------------------
// IDLE      | line high, waiting for a falling edge
// START     | confirming start bit at its midpoint
// DATA      | sampling 8 data bits at bit centres, LSB first
// STOP      | sampling stop bit; accept byte or flag framing error
// WAIT_HIGH | after a framing error, wait for line to return high
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_rx,
    output byte_t o_byte,
    output logic  o_byte_ok,
    output logic  o_frame_err,
    output logic  o_idle,
    output logic  o_start
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       r_sync;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    byte_t            r_shift;

    logic             w_rxs;
    rx_state_t        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_bit_idx_nxt;
    byte_t            w_shift_nxt;
    logic             w_byte_ok;
    logic             w_frame_err;

    assign w_rxs = r_sync[1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync    <= 2'b11;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_sync    <= {r_sync[0], i_rx};
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + CNT_W'(1);
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_byte_ok     = 1'b0;
        w_frame_err   = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_rxs) w_state_nxt = START;
            end
            START: begin
                if (r_cnt == HALF_M1) begin
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = w_rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_nxt     = '0;
                    w_shift_nxt   = {w_rxs, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (r_cnt == FULL_M1) begin
                    if (w_rxs) begin
                        w_byte_ok   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_nxt = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (w_rxs) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        // Counter restarts on every state change; IDLE and WAIT_HIGH don't time anything.
        if (w_state_nxt != r_state || r_state == IDLE || r_state == WAIT_HIGH) begin
            w_cnt_nxt = '0;
        end
    end

    assign o_byte      = r_shift;
    assign o_byte_ok   = w_byte_ok;
    assign o_frame_err = w_frame_err;
    assign o_idle      = (r_state == IDLE);
    assign o_start     = (r_state == IDLE) && !w_rxs;

endmodule

// File: rtl/uart_word_rx.sv
// Assembles pairs of received serial bytes into a 16-bit display word.
// A lone high byte is dropped after TIMEOUT_BITS idle bit-times.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_rx           : asynchronous serial input, idles high
//   o_word         : last assembled word, first byte in [15:8]; INIT_WORD after reset
//   o_word_valid   : one-cycle pulse when o_word updates
//   o_frame_err    : one-cycle pulse on a bad stop bit
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int          CLK_HZ       = 12_000_000,
    parameter int          BAUD         = 115_200,
    parameter int          CLKS_PER_BIT = CLK_HZ / BAUD,
    parameter int          TIMEOUT_BITS = 20,
    parameter logic [15:0] INIT_WORD    = 16'hC931
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx,
    output logic [15:0] o_word,
    output logic        o_word_valid,
    output logic        o_frame_err
);

    localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TCNT_W = $clog2(TO_CYC);
    localparam logic [TCNT_W-1:0] TO_M1 = TCNT_W'(TO_CYC - 1);

    byte_t             w_byte;
    logic              w_byte_ok;
    logic              w_frame_err;
    logic              w_idle;
    logic              w_start;

    logic              r_phase;
    byte_t             r_hi;
    logic [TCNT_W-1:0] r_tcnt;
    logic [15:0]       r_word;
    logic              r_word_valid;
    logic              r_frame_err;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_byte (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rx        (i_rx),
        .o_byte      (w_byte),
        .o_byte_ok   (w_byte_ok),
        .o_frame_err (w_frame_err),
        .o_idle      (w_idle),
        .o_start     (w_start)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase      <= 1'b0;
            r_hi         <= '0;
            r_tcnt       <= '0;
            r_word       <= INIT_WORD;
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            r_frame_err  <= w_frame_err;
            if (w_byte_ok) begin
                r_tcnt <= '0;
                if (!r_phase) begin
                    r_hi    <= w_byte;
                    r_phase <= 1'b1;
                end else begin
                    r_word       <= {r_hi, w_byte};
                    r_word_valid <= 1'b1;
                    r_phase      <= 1'b0;
                end
            end else if (w_frame_err) begin
                r_tcnt  <= '0;
                r_phase <= 1'b0;
            end else if (w_idle && r_phase) begin
                if (r_tcnt == TO_M1) begin
                    r_tcnt <= '0;
                    // A start edge in the expiry cycle keeps the pending high byte.
                    if (!w_start) r_phase <= 1'b0;
                end else begin
                    r_tcnt <= r_tcnt + TCNT_W'(1);
                end
            end else begin
                r_tcnt <= '0;
            end
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;
    assign o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_uart_word_rx.sv
module tb_uart_word_rx;

    localparam int CPB = 104;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [15:0] word;
    logic        wv;
    logic        fe;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int fe_cnt = 0;
    int v0;
    int f0;

    logic [15:0] exp_words[$];
    int          exp_cycs[$];
    logic [15:0] ew;
    int          ec;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_word_rx dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx         (rx),
        .o_word       (word),
        .o_word_valid (wv),
        .o_frame_err  (fe)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one full frame back-to-back with whatever follows.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                             input logic expect_word, input logic [15:0] w);
        rx = 1'b0;
        if (expect_word) begin
            exp_words.push_back(w);
            exp_cycs.push_back(cyc + 991);
        end
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    // Scoreboard: every WORD_VALID pops one expected word and its expected cycle.
    always @(negedge clk) begin
        if (wv) begin
            valid_cnt++;
            chk("valid_expected", 32'(exp_words.size() > 0), 32'd1);
            if (exp_words.size() > 0) begin
                ew = exp_words.pop_front();
                ec = exp_cycs.pop_front();
                chk("word_value", 32'(word), 32'(ew));
                chk("word_timing", 32'(cyc), 32'(ec));
            end
            chk("valid_and_ferr_exclusive", 32'(fe), 32'd0);
        end
        if (fe) fe_cnt++;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog cycles=%0d limit=60000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        chk("reset_word", 32'(word), 32'h0000_C931);
        chk("reset_valid", 32'(wv), 32'd0);
        chk("reset_ferr", 32'(fe), 32'd0);

        repeat (1000) @(negedge clk);
        chk("idle_word", 32'(word), 32'h0000_C931);
        chk("idle_valid_cnt", 32'(valid_cnt), 32'd0);
        chk("idle_ferr_cnt", 32'(fe_cnt), 32'd0);

        send_byte(8'h12, 1'b1, 1'b0, 16'h0000);
        send_byte(8'h34, 1'b1, 1'b1, 16'h1234);
        repeat (20) @(negedge clk);
        chk("pair_1234_word", 32'(word), 32'h0000_1234);
        chk("pair_1234_cnt", 32'(valid_cnt), 32'd1);

        v0 = valid_cnt;
        f0 = fe_cnt;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        chk("glitch_valid", 32'(valid_cnt - v0), 32'd0);
        chk("glitch_ferr", 32'(fe_cnt - f0), 32'd0);
        chk("glitch_word", 32'(word), 32'h0000_1234);

        send_byte(8'hAB, 1'b0, 1'b0, 16'h0000);
        repeat (300) @(negedge clk);
        rx = 1'b1;
        repeat (50) @(negedge clk);
        chk("break_ferr_cnt", 32'(fe_cnt - f0), 32'd1);
        chk("break_valid", 32'(valid_cnt - v0), 32'd0);
        chk("break_word", 32'(word), 32'h0000_1234);
        send_byte(8'h56, 1'b1, 1'b0, 16'h0000);
        send_byte(8'h78, 1'b1, 1'b1, 16'h5678);
        repeat (20) @(negedge clk);
        chk("after_break_word", 32'(word), 32'h0000_5678);

        send_byte(8'h9A, 1'b1, 1'b0, 16'h0000);
        repeat (25 * CPB) @(negedge clk);
        chk("timeout_hold_word", 32'(word), 32'h0000_5678);
        send_byte(8'hBC, 1'b1, 1'b0, 16'h0000);
        send_byte(8'hDE, 1'b1, 1'b1, 16'hBCDE);
        repeat (20) @(negedge clk);
        chk("timeout_word", 32'(word), 32'h0000_BCDE);
        chk("timeout_valid_cnt", 32'(valid_cnt), 32'd3);

        // Leave a pending high byte, then reset in the middle of data bit 4.
        send_byte(8'h77, 1'b1, 1'b0, 16'h0000);
        v0 = valid_cnt;
        f0 = fe_cnt;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midframe_rst_word", 32'(word), 32'h0000_C931);
        chk("midframe_rst_valid", 32'(wv), 32'd0);
        chk("midframe_rst_ferr", 32'(fe), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (200) @(negedge clk);
        chk("post_rst_valid", 32'(valid_cnt - v0), 32'd0);
        chk("post_rst_ferr", 32'(fe_cnt - f0), 32'd0);
        send_byte(8'h11, 1'b1, 1'b0, 16'h0000);
        send_byte(8'h22, 1'b1, 1'b1, 16'h1122);
        repeat (20) @(negedge clk);
        chk("post_rst_word", 32'(word), 32'h0000_1122);

        chk("total_valid_cnt", 32'(valid_cnt), 32'd4);
        chk("total_ferr_cnt", 32'(fe_cnt), 32'd1);
        chk("scoreboard_empty", 32'(exp_words.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
